// File: rtl/soc_addr_router.sv
// Address-map router: one upstream request port fanned out to NumRules slaves plus an error slave.
// Optional unmapped-address capture is enabled by defining SOC_ROUTER_ERR_LOG_EN.
module soc_addr_router #(
    parameter int unsigned NumRules  = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxOutst  = 8,
    parameter logic [NumRules-1:0][AddrWidth-1:0] RuleBase = {
        64'h0000_0000_8000_0000, 64'h0000_0000_1000_0000,
        64'h0000_0000_0200_0000, 64'h0000_0000_0010_0000},
    parameter logic [NumRules-1:0][AddrWidth-1:0] RuleLen = {
        64'h0000_0000_4000_0000, 64'h0000_0000_0000_2000,
        64'h0000_0000_000C_0000, 64'h0000_0000_0001_0000},
    parameter logic [NumRules-1:0] RuleValid = '1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AddrWidth-1:0]          req_addr_i,
    input  logic                          req_we_i,
    input  logic [DataWidth-1:0]          req_wdata_i,
    input  logic [DataWidth/8-1:0]        req_be_i,
    output logic [NumRules-1:0]           slv_req_valid_o,
    input  logic [NumRules-1:0]           slv_req_ready_i,
    output logic [AddrWidth-1:0]          slv_addr_o,
    output logic                          slv_we_o,
    output logic [DataWidth-1:0]          slv_wdata_o,
    output logic [DataWidth/8-1:0]        slv_be_o,
    input  logic [NumRules-1:0]           slv_rsp_valid_i,
    output logic [NumRules-1:0]           slv_rsp_ready_o,
    input  logic [NumRules*DataWidth-1:0] slv_rsp_rdata_i,
    input  logic [NumRules-1:0]           slv_rsp_err_i,
`ifdef SOC_ROUTER_ERR_LOG_EN
    output logic                          err_valid_o,
    output logic [AddrWidth-1:0]          err_addr_o,
    input  logic                          err_clr_i,
`endif
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o
);

    localparam int unsigned TgtWidth = $clog2(NumRules + 1);
    localparam int unsigned CntWidth = $clog2(MaxOutst + 1);
    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(NumRules);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutst);

    logic [TgtWidth-1:0]  cur_tgt_q, cur_tgt_d;
    logic [CntWidth-1:0]  outst_q, outst_d;
    logic                 err_pend_q, err_pend_d;
    logic                 oreg_valid_q, oreg_valid_d;
    logic [AddrWidth-1:0] oreg_addr_q;
    logic                 oreg_we_q;
    logic [DataWidth-1:0] oreg_wdata_q;
    logic [BeWidth-1:0]   oreg_be_q;

    logic [TgtWidth-1:0]  dec_tgt;
    logic                 cur_is_err, outst_nz, stall, oreg_drain;
    logic                 accept, accept_err, rsp_hs;
    logic                 sel_req_ready, sel_rsp_valid, sel_rsp_err;
    logic [DataWidth-1:0] sel_rsp_rdata;

    // Iterate high to low so the lowest matching rule index wins
    always_comb begin
        dec_tgt = ErrTgt;
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (RuleValid[i] &&
                ({1'b0, req_addr_i} >= {1'b0, RuleBase[i]}) &&
                ({1'b0, req_addr_i} < ({1'b0, RuleBase[i]} + {1'b0, RuleLen[i]}))) begin
                dec_tgt = TgtWidth'(i);
            end
        end
    end

    // Mux over ports by compare so the ERR index never selects out of range
    always_comb begin
        sel_req_ready   = 1'b0;
        sel_rsp_valid   = 1'b0;
        sel_rsp_err     = 1'b0;
        sel_rsp_rdata   = '0;
        slv_req_valid_o = '0;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (cur_tgt_q == TgtWidth'(i)) begin
                sel_req_ready      = slv_req_ready_i[i];
                sel_rsp_valid      = slv_rsp_valid_i[i];
                sel_rsp_err        = slv_rsp_err_i[i];
                sel_rsp_rdata      = slv_rsp_rdata_i[i*DataWidth +: DataWidth];
                slv_req_valid_o[i] = oreg_valid_q;
            end
        end
    end

    always_comb begin
        cur_is_err  = (cur_tgt_q == ErrTgt);
        outst_nz    = (outst_q != '0);
        stall       = (outst_nz && (dec_tgt != cur_tgt_q)) || (outst_q == MaxCnt);
        oreg_drain  = oreg_valid_q && sel_req_ready;
        req_ready_o = !stall && (!oreg_valid_q || oreg_drain) && !err_pend_q;
        accept      = req_valid_i && req_ready_o;
        accept_err  = accept && (dec_tgt == ErrTgt);

        slv_rsp_ready_o = '1;
        if (cur_is_err) begin
            rsp_valid_o = err_pend_q;
            rsp_rdata_o = '0;
            rsp_err_o   = err_pend_q;
        end else begin
            rsp_valid_o = outst_nz && sel_rsp_valid;
            rsp_rdata_o = outst_nz ? sel_rsp_rdata : '0;
            rsp_err_o   = outst_nz && sel_rsp_err;
            for (int i = 0; i < int'(NumRules); i++) begin
                if (outst_nz && (cur_tgt_q == TgtWidth'(i))) begin
                    slv_rsp_ready_o[i] = rsp_ready_i;
                end
            end
        end
        rsp_hs = rsp_valid_o && rsp_ready_i;
    end

    always_comb begin
        cur_tgt_d    = accept ? dec_tgt : cur_tgt_q;
        oreg_valid_d = oreg_valid_q;
        if (oreg_drain) begin
            oreg_valid_d = 1'b0;
        end
        if (accept && !accept_err) begin
            oreg_valid_d = 1'b1;
        end
        unique case ({accept, rsp_hs})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        err_pend_d = err_pend_q;
        if (accept_err) begin
            err_pend_d = 1'b1;
        end else if (rsp_hs && cur_is_err) begin
            err_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_tgt_q    <= '0;
            outst_q      <= '0;
            err_pend_q   <= 1'b0;
            oreg_valid_q <= 1'b0;
            oreg_addr_q  <= '0;
            oreg_we_q    <= 1'b0;
            oreg_wdata_q <= '0;
            oreg_be_q    <= '0;
        end else begin
            cur_tgt_q    <= cur_tgt_d;
            outst_q      <= outst_d;
            err_pend_q   <= err_pend_d;
            oreg_valid_q <= oreg_valid_d;
            if (accept && !accept_err) begin
                oreg_addr_q  <= req_addr_i;
                oreg_we_q    <= req_we_i;
                oreg_wdata_q <= req_wdata_i;
                oreg_be_q    <= req_be_i;
            end
        end
    end

    assign slv_addr_o  = oreg_addr_q;
    assign slv_we_o    = oreg_we_q;
    assign slv_wdata_o = oreg_wdata_q;
    assign slv_be_o    = oreg_be_q;

`ifdef SOC_ROUTER_ERR_LOG_EN
    logic                 err_valid_q, err_valid_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;

    // A capture in the same cycle as a clear takes priority
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (accept_err && (!err_valid_q || err_clr_i)) begin
            err_valid_d = 1'b1;
            err_addr_d  = req_addr_i;
        end else if (err_clr_i) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`endif

endmodule

// File: tb/tb_soc_addr_router.sv
// Self-checking bench for soc_addr_router: vector table plus multi-cycle corner sequences.
// Responses are checked against a scoreboard queue; log checks apply when SOC_ROUTER_ERR_LOG_EN is set.
module tb_soc_addr_router;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] rdata;
        int          tgt;
    } vec_t;

    logic         clk, rst;
    logic         req_valid, req_ready_o, req_we;
    logic [63:0]  req_addr, req_wdata;
    logic [7:0]   req_be;
    logic [3:0]   slv_req_valid_o, slv_req_ready;
    logic [63:0]  slv_addr_o, slv_wdata_o;
    logic         slv_we_o;
    logic [7:0]   slv_be_o;
    logic [3:0]   slv_rsp_valid, slv_rsp_ready_o, slv_rsp_err;
    logic [255:0] slv_rsp_rdata;
    logic         rsp_valid_o, rsp_ready, rsp_err_o;
    logic [63:0]  rsp_rdata_o;
`ifdef SOC_ROUTER_ERR_LOG_EN
    logic         err_valid_o, err_clr;
    logic [63:0]  err_addr_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;
    vec_t        vecs[12];

    soc_addr_router dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr),
        .req_we_i        (req_we),
        .req_wdata_i     (req_wdata),
        .req_be_i        (req_be),
        .slv_req_valid_o (slv_req_valid_o),
        .slv_req_ready_i (slv_req_ready),
        .slv_addr_o      (slv_addr_o),
        .slv_we_o        (slv_we_o),
        .slv_wdata_o     (slv_wdata_o),
        .slv_be_o        (slv_be_o),
        .slv_rsp_valid_i (slv_rsp_valid),
        .slv_rsp_ready_o (slv_rsp_ready_o),
        .slv_rsp_rdata_i (slv_rsp_rdata),
        .slv_rsp_err_i   (slv_rsp_err),
`ifdef SOC_ROUTER_ERR_LOG_EN
        .err_valid_o     (err_valid_o),
        .err_addr_o      (err_addr_o),
        .err_clr_i       (err_clr),
`endif
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every upstream response handshake pops one expected {err, rdata}
    always @(negedge clk) begin
        if (!rst && rsp_valid_o && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                         rsp_rdata_o, rsp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, mon_e[63:0]);
                check("rsp_err", 64'(rsp_err_o), 64'(mon_e[64]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        logic [3:0] exp_oh;
        exp_oh = (v.tgt < 4) ? 4'(1 << v.tgt) : 4'b0;
        tick();
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = ~v.addr;
        req_be    = 8'hA5;
        @(negedge clk);
        check("txn_ready", 64'(req_ready_o), 64'd1);
        exp_q.push_back((v.tgt < 4) ? {1'b0, v.rdata} : {1'b1, 64'd0});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("txn_slv_valid", 64'(slv_req_valid_o), 64'(exp_oh));
        if (v.tgt < 4) begin
            check("txn_slv_addr", slv_addr_o, v.addr);
            check("txn_slv_wdata", slv_wdata_o, ~v.addr);
            check("txn_slv_we_be", {55'd0, slv_we_o, slv_be_o}, {55'd0, v.we, 8'hA5});
            check("txn_no_early_rsp", 64'(rsp_valid_o), 64'd0);
            tick();
            slv_rsp_valid[v.tgt] = 1'b1;
            slv_rsp_rdata[v.tgt*64 +: 64] = v.rdata;
            @(negedge clk);
            check("txn_rsp_valid", 64'(rsp_valid_o), 64'd1);
            tick();
            slv_rsp_valid = '0;
        end else begin
            check("txn_err_rsp_valid", 64'(rsp_valid_o), 64'd1);
            tick();
        end
        @(negedge clk);
        check("txn_rsp_done", 64'(rsp_valid_o), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{64'h0000_0000_8000_0010, 1'b0, 64'hDEAD, 3};
        vecs[1]  = '{64'h0000_0000_0000_0000, 1'b0, 64'h0, 4};
        vecs[2]  = '{64'h0000_0000_1000_1FFF, 1'b0, 64'hB007, 2};
        vecs[3]  = '{64'h0000_0000_1000_2000, 1'b0, 64'h0, 4};
        vecs[4]  = '{64'h0000_0000_000F_FFFF, 1'b0, 64'h0, 4};
        vecs[5]  = '{64'h0000_0000_0010_0000, 1'b1, 64'h0, 0};
        vecs[6]  = '{64'h0000_0000_0010_FFFF, 1'b0, 64'h6010, 0};
        vecs[7]  = '{64'h0000_0000_0011_0000, 1'b0, 64'h0, 4};
        vecs[8]  = '{64'h0000_0000_020B_FFF8, 1'b0, 64'hC1C1_0000_1234, 1};
        vecs[9]  = '{64'h0000_0000_BFFF_FFF8, 1'b0, 64'hD0D0, 3};
        vecs[10] = '{64'h0000_0000_C000_0000, 1'b0, 64'h0, 4};
        vecs[11] = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 64'h0, 4};

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_be = '0;
        slv_req_ready = 4'hF; slv_rsp_valid = '0; slv_rsp_rdata = '0; slv_rsp_err = '0;
        rsp_ready = 1'b1;
`ifdef SOC_ROUTER_ERR_LOG_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_slv_valid", 64'(slv_req_valid_o), 64'd0);
        check("rst_rsp", {rsp_rdata_o[62:0], rsp_valid_o}, 64'd0);
        check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
`ifdef SOC_ROUTER_ERR_LOG_EN
        check("rst_err_valid", 64'(err_valid_o), 64'd0);
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i]);
        end

`ifdef SOC_ROUTER_ERR_LOG_EN
        check("log_first_valid", 64'(err_valid_o), 64'd1);
        check("log_first_addr", err_addr_o, 64'd0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("log_cleared", 64'(err_valid_o), 64'd0);
        tick();
        req_valid = 1'b1;
        req_addr  = 64'h1000_2000;
        err_clr   = 1'b1;
        @(negedge clk);
        check("log_clr_cap_ready", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b1, 64'd0});
        tick();
        req_valid = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        check("log_clr_cap_valid", 64'(err_valid_o), 64'd1);
        check("log_clr_cap_addr", err_addr_o, 64'h1000_2000);
        do_txn('{64'h0000_0000_0000_0040, 1'b0, 64'h0, 4});
        check("log_sticky_addr", err_addr_o, 64'h1000_2000);
`endif

        // DRAM then CLINT: CLINT must wait for the delayed DRAM response
        tick();
        req_valid = 1'b1;
        req_addr  = 64'h8000_0100;
        @(negedge clk);
        check("b2b_dram_ready", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b0, 64'h1111});
        tick();
        req_addr = 64'h0200_0040;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("b2b_stall", 64'(req_ready_o), 64'd0);
            tick();
        end
        slv_rsp_valid[3] = 1'b1;
        slv_rsp_rdata[3*64 +: 64] = 64'h1111;
        @(negedge clk);
        check("b2b_stall_hs", 64'(req_ready_o), 64'd0);
        tick();
        slv_rsp_valid = '0;
        @(negedge clk);
        check("b2b_clint_ready", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b0, 64'h2222});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_clint_valid", 64'(slv_req_valid_o), 64'b0010);
        tick();
        slv_rsp_valid[1] = 1'b1;
        slv_rsp_rdata[1*64 +: 64] = 64'h2222;
        @(negedge clk);
        check("b2b_clint_rsp", 64'(rsp_valid_o), 64'd1);
        tick();
        slv_rsp_valid = '0;

        // Fill to MaxOutst with no responses, then exercise the counter limits
        req_valid = 1'b1;
        req_addr  = 64'h8000_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("max_fill", 64'(req_ready_o), 64'd1);
            exp_q.push_back({1'b0, 64'h100 + 64'(i)});
            tick();
            req_addr = req_addr + 64'd8;
        end
        slv_rsp_valid[3] = 1'b1;
        slv_rsp_rdata[3*64 +: 64] = 64'h100;
        @(negedge clk);
        check("max_full", 64'(req_ready_o), 64'd0);
        tick();
        slv_rsp_rdata[3*64 +: 64] = 64'h101;
        @(negedge clk);
        check("max_both", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b0, 64'h108});
        tick();
        slv_rsp_valid = '0;
        @(negedge clk);
        check("max_refill", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b0, 64'h109});
        tick();
        @(negedge clk);
        check("max_refull", 64'(req_ready_o), 64'd0);
        for (int k = 2; k < 10; k++) begin
            tick();
            req_valid = 1'b0;
            slv_rsp_valid[3] = 1'b1;
            slv_rsp_rdata[3*64 +: 64] = 64'h100 + 64'(k);
        end
        tick();
        slv_rsp_valid = '0;
        @(negedge clk);
        check("max_drained_ready", 64'(req_ready_o), 64'd1);
        check("max_sb_empty", 64'(exp_q.size()), 64'd0);

        // Spurious response on a non-current port is drained, never forwarded
        tick();
        req_valid = 1'b1;
        req_addr  = 64'h8000_0200;
        @(negedge clk);
        check("spur_ready", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b0, 64'h3333});
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        slv_rsp_valid[2] = 1'b1;
        slv_rsp_rdata[2*64 +: 64] = 64'hBAD;
        @(negedge clk);
        check("spur_rsp_ready", 64'(slv_rsp_ready_o), 64'b0111);
        check("spur_no_rsp", 64'(rsp_valid_o), 64'd0);
        tick();
        rsp_ready = 1'b1;
        slv_rsp_valid = '0;

        // Reset with two DRAM requests in flight
        req_valid = 1'b1;
        req_addr  = 64'h8000_0208;
        @(negedge clk);
        check("mid_ready", 64'(req_ready_o), 64'd1);
        tick();
        req_valid = 1'b0;
        check("mid_pre_rst_valid", 64'(slv_req_valid_o), 64'b1000);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_slv_valid", 64'(slv_req_valid_o), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        tick();
        rst = 1'b0;
        slv_rsp_valid[3] = 1'b1;
        slv_rsp_rdata[3*64 +: 64] = 64'h3333;
        @(negedge clk);
        check("late_rsp_dropped", 64'(rsp_valid_o), 64'd0);
        check("late_rsp_drain", 64'(slv_rsp_ready_o), 64'hF);
        check("late_ready", 64'(req_ready_o), 64'd1);
        tick();
        slv_rsp_valid = '0;
        req_valid = 1'b1;
        req_addr  = 64'h0200_0000;
        @(negedge clk);
        check("post_rst_clint_ready", 64'(req_ready_o), 64'd1);
        exp_q.push_back({1'b0, 64'h4444});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_clint_valid", 64'(slv_req_valid_o), 64'b0010);
        tick();
        slv_rsp_valid[1] = 1'b1;
        slv_rsp_rdata[1*64 +: 64] = 64'h4444;
        @(negedge clk);
        check("post_rst_rsp", 64'(rsp_valid_o), 64'd1);
        tick();
        slv_rsp_valid = '0;
        @(negedge clk);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
